// File: rtl/tlb_asid.sv
// tlb_asid: fully associative, ASID-tagged Sv32/Sv39 TLB.
// Registered lookup, SFENCE.VMA flushes, NRU replacement.
module tlb_asid #(
  parameter int XLEN        = 32,
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_WIDTH  = 9
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          lookup_valid,
  input  logic [XLEN-1:0]               lookup_vaddr,
  input  logic [ASID_WIDTH-1:0]         lookup_asid,
  input  logic                          lookup_is_store,
  input  logic                          lookup_is_fetch,
  output logic                          resp_valid,
  output logic                          resp_hit,
  output logic [XLEN-1:0]               resp_paddr,
  output logic                          resp_page_fault,
  input  logic                          update_valid,
  input  logic [XLEN-1:0]               update_vpn,
  input  logic [XLEN-1:0]               update_ppn,
  input  logic [7:0]                    update_pte,
  input  logic [1:0]                    update_level,
  input  logic [ASID_WIDTH-1:0]         update_asid,
  input  logic [1:0]                    privilege_mode,
  input  logic                          mstatus_sum,
  input  logic                          mstatus_mxr,
  input  logic                          translation_enabled,
  input  logic                          flush_valid,
  input  logic                          flush_use_vaddr,
  input  logic                          flush_use_asid,
  input  logic [XLEN-1:0]               flush_vaddr,
  input  logic [ASID_WIDTH-1:0]         flush_asid,
  output logic [$clog2(TLB_ENTRIES):0]  occupancy
);

  localparam int N  = TLB_ENTRIES;
  localparam int IW = $clog2(N);
  localparam int OW = IW + 1;
  localparam int LB = (XLEN == 32) ? 10 : 9;
  localparam int VW = (XLEN == 32) ? 20 : 27;
  localparam logic [XLEN-1:0] VMASK = XLEN'((64'd1 << VW) - 64'd1);

  function automatic logic [XLEN-1:0] lmask(input logic [1:0] l);
    logic [XLEN-1:0] m;
    m = '0;
    for (int b = 0; b < 2 * LB; b++)
      if (b < LB * int'(l)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic va_match(input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b,
                                    input logic [1:0] l);
    return ((a ^ b) & ~lmask(l)) == '0;
  endfunction

  logic [N-1:0]          v_q, ref_q;
  logic [XLEN-1:0]       vpn_q  [N];
  logic [XLEN-1:0]       ppn_q  [N];
  logic [7:0]            pte_q  [N];
  logic [1:0]            lvl_q  [N];
  logic [ASID_WIDTH-1:0] asid_q [N];

  logic [XLEN-1:0] lk_vpn;
  logic [N-1:0]    lk_m;
  logic            lk_any;
  logic [IW-1:0]   lk_idx;

  // associative match; lowest index wins
  always_comb begin
    lk_vpn = '0;
    lk_vpn[VW-1:0] = lookup_vaddr[VW+11:12];
    lk_m = '0;
    for (int i = 0; i < N; i++)
      lk_m[i] = v_q[i]
        && (pte_q[i][5] || asid_q[i] == lookup_asid)
        && va_match(vpn_q[i], lk_vpn, lvl_q[i]);
    lk_any = 1'b0;
    lk_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (lk_m[i]) begin
        lk_any = 1'b1;
        lk_idx = IW'(i);
      end
  end

  logic [7:0]       h_pte;
  logic [1:0]       h_lvl;
  logic [XLEN-1:0]  h_ppn, h_lm, h_pa_ppn;
  logic [XLEN+11:0] h_pa;
  logic             h_fault, is_ld, xlt_hit;

  // physical address and permission check of the winner
  always_comb begin
    h_pte    = pte_q[lk_idx];
    h_lvl    = lvl_q[lk_idx];
    h_ppn    = ppn_q[lk_idx];
    h_lm     = lmask(h_lvl);
    h_pa_ppn = (h_ppn & ~h_lm) | (lk_vpn & h_lm);
    h_pa     = {h_pa_ppn, lookup_vaddr[11:0]};
    is_ld    = !lookup_is_store && !lookup_is_fetch;
    h_fault  = !h_pte[0]
      || (!h_pte[1] && !h_pte[2] && !h_pte[3])
      || (h_pte[2] && !h_pte[1])
      || !h_pte[6]
      || (lookup_is_store && !h_pte[7])
      || (h_lvl != 2'd0 && (h_ppn & h_lm) != '0)
      || (privilege_mode == 2'd0 && !h_pte[4])
      || (privilege_mode == 2'd1 && h_pte[4] && !mstatus_sum)
      || (privilege_mode == 2'd1 && h_pte[4] && lookup_is_fetch)
      || (lookup_is_fetch && !h_pte[3])
      || (lookup_is_store && !h_pte[2])
      || (is_ld && !h_pte[1] && !(h_pte[3] && mstatus_mxr));
  end

  assign xlt_hit = lookup_valid && translation_enabled && lk_any;

  logic [XLEN-1:0] fl_vpn;
  logic [N-1:0]    fl_m;

  // SFENCE.VMA victim set
  always_comb begin
    fl_vpn = '0;
    fl_vpn[VW-1:0] = flush_vaddr[VW+11:12];
    fl_m = '0;
    for (int i = 0; i < N; i++) begin
      case ({flush_use_vaddr, flush_use_asid})
        2'b00: fl_m[i] = v_q[i];
        2'b10: fl_m[i] = v_q[i]
          && va_match(vpn_q[i], fl_vpn, lvl_q[i]);
        2'b01: fl_m[i] = v_q[i] && !pte_q[i][5]
          && asid_q[i] == flush_asid;
        default: fl_m[i] = v_q[i] && !pte_q[i][5]
          && asid_q[i] == flush_asid
          && va_match(vpn_q[i], fl_vpn, lvl_q[i]);
      endcase
      if (!flush_valid) fl_m[i] = 1'b0;
    end
  end

  logic [N-1:0]    v_post, up_same;
  logic [XLEN-1:0] up_vpn;
  logic            same_f, inv_f;
  logic [IW-1:0]   same_i, inv_i, nru_i, wr_idx;

  // fill slot: same tag, else first free, else first NRU
  always_comb begin
    v_post = v_q & ~fl_m;
    up_vpn = update_vpn & VMASK;
    for (int i = 0; i < N; i++)
      up_same[i] = v_post[i] && vpn_q[i] == up_vpn
        && lvl_q[i] == update_level
        && (asid_q[i] == update_asid
            || (pte_q[i][5] && update_pte[5]));
    same_f = 1'b0;
    inv_f  = 1'b0;
    same_i = '0;
    inv_i  = '0;
    nru_i  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (up_same[i]) begin
        same_f = 1'b1;
        same_i = IW'(i);
      end
      if (!v_post[i]) begin
        inv_f = 1'b1;
        inv_i = IW'(i);
      end
      if (!ref_q[i]) nru_i = IW'(i);
    end
    wr_idx = same_f ? same_i : (inv_f ? inv_i : nru_i);
  end

  logic [N-1:0] ref_set, ref_base, ref_d;

  // NRU: never let every ref bit be set
  always_comb begin
    ref_set = '0;
    if (xlt_hit) ref_set[lk_idx] = !fl_m[lk_idx];
    if (update_valid) ref_set[wr_idx] = 1'b1;
    ref_base = ref_q & ~fl_m;
    ref_d = (&(ref_base | ref_set)) ? ref_set
                                   : (ref_base | ref_set);
  end

  // entry table: flush first, then fill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      ref_q <= '0;
      for (int i = 0; i < N; i++) begin
        vpn_q[i]  <= '0;
        ppn_q[i]  <= '0;
        pte_q[i]  <= '0;
        lvl_q[i]  <= '0;
        asid_q[i] <= '0;
      end
    end else begin
      v_q   <= v_post;
      ref_q <= ref_d;
      if (update_valid) begin
        v_q[wr_idx]    <= 1'b1;
        vpn_q[wr_idx]  <= up_vpn;
        ppn_q[wr_idx]  <= update_ppn;
        pte_q[wr_idx]  <= update_pte;
        lvl_q[wr_idx]  <= update_level;
        asid_q[wr_idx] <= update_asid;
      end
    end
  end

  // registered response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_paddr      <= '0;
      resp_page_fault <= 1'b0;
    end else begin
      resp_valid      <= lookup_valid;
      resp_hit        <= 1'b0;
      resp_paddr      <= '0;
      resp_page_fault <= 1'b0;
      if (lookup_valid && !translation_enabled) begin
        resp_hit   <= 1'b1;
        resp_paddr <= lookup_vaddr;
      end else if (xlt_hit) begin
        resp_hit        <= 1'b1;
        resp_paddr      <= h_pa[XLEN-1:0];
        resp_page_fault <= h_fault;
      end
    end
  end

  // valid-entry count
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < N; i++)
      occupancy = occupancy + OW'(v_q[i]);
  end

  logic unused_bits;
  assign unused_bits = ^{h_pa[XLEN+11:XLEN], h_pte,
                         lookup_vaddr, flush_vaddr};

endmodule

// File: tb/tb_tlb_asid.sv
// tb_tlb_asid: directed vector table for tlb_asid (Sv32, 16 entries).
// One vector per cycle; response and occupancy checked after the edge.
module tb_tlb_asid;

  logic        clk, reset_n;
  logic        lookup_valid, lookup_is_store, lookup_is_fetch;
  logic [31:0] lookup_vaddr;
  logic [8:0]  lookup_asid;
  logic        resp_valid, resp_hit, resp_page_fault;
  logic [31:0] resp_paddr;
  logic        update_valid;
  logic [31:0] update_vpn, update_ppn;
  logic [7:0]  update_pte;
  logic [1:0]  update_level;
  logic [8:0]  update_asid;
  logic [1:0]  privilege_mode;
  logic        mstatus_sum, mstatus_mxr, translation_enabled;
  logic        flush_valid, flush_use_vaddr, flush_use_asid;
  logic [31:0] flush_vaddr;
  logic [8:0]  flush_asid;
  logic [4:0]  occupancy;

  tlb_asid #(.XLEN(32), .TLB_ENTRIES(16), .ASID_WIDTH(9)) dut (
    .clk(clk), .reset_n(reset_n),
    .lookup_valid(lookup_valid), .lookup_vaddr(lookup_vaddr),
    .lookup_asid(lookup_asid), .lookup_is_store(lookup_is_store),
    .lookup_is_fetch(lookup_is_fetch),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_paddr(resp_paddr), .resp_page_fault(resp_page_fault),
    .update_valid(update_valid), .update_vpn(update_vpn),
    .update_ppn(update_ppn), .update_pte(update_pte),
    .update_level(update_level), .update_asid(update_asid),
    .privilege_mode(privilege_mode), .mstatus_sum(mstatus_sum),
    .mstatus_mxr(mstatus_mxr),
    .translation_enabled(translation_enabled),
    .flush_valid(flush_valid), .flush_use_vaddr(flush_use_vaddr),
    .flush_use_asid(flush_use_asid), .flush_vaddr(flush_vaddr),
    .flush_asid(flush_asid), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        up;
    logic [31:0] uvpn;
    logic [31:0] uppn;
    logic [7:0]  upte;
    logic [1:0]  ulvl;
    logic [8:0]  uasid;
    logic        fl;
    logic        fva;
    logic        fas;
    logic [31:0] fvaddr;
    logic [8:0]  fasid;
    logic        lk;
    logic [31:0] va;
    logic [8:0]  asid;
    logic        st;
    logic        fe;
    logic [1:0]  priv;
    logic        sum;
    logic        mxr;
    logic        te;
    logic        ehit;
    logic [31:0] epa;
    logic        eflt;
    logic [4:0]  eocc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t base();
    vec_t v;
    v = '0;
    v.priv = 2'd1;
    v.te = 1'b1;
    return v;
  endfunction

  function automatic vec_t upd(input vec_t b, input logic [31:0] vpn,
                               input logic [31:0] ppn,
                               input logic [7:0] pte,
                               input logic [1:0] lvl,
                               input logic [8:0] asid);
    vec_t v;
    v = b;
    v.up = 1'b1;
    v.uvpn = vpn;
    v.uppn = ppn;
    v.upte = pte;
    v.ulvl = lvl;
    v.uasid = asid;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t b, input logic uva,
                              input logic uas, input logic [31:0] va,
                              input logic [8:0] asid);
    vec_t v;
    v = b;
    v.fl = 1'b1;
    v.fva = uva;
    v.fas = uas;
    v.fvaddr = va;
    v.fasid = asid;
    return v;
  endfunction

  function automatic vec_t lk(input logic [31:0] va,
                              input logic [8:0] asid, input logic h,
                              input logic [31:0] pa, input logic f);
    vec_t v;
    v = base();
    v.lk = 1'b1;
    v.va = va;
    v.asid = asid;
    v.ehit = h;
    v.epa = pa;
    v.eflt = f;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic [4:0] occ);
    v.eocc = occ;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    update_valid = v.up;
    update_vpn = v.uvpn;
    update_ppn = v.uppn;
    update_pte = v.upte;
    update_level = v.ulvl;
    update_asid = v.uasid;
    flush_valid = v.fl;
    flush_use_vaddr = v.fva;
    flush_use_asid = v.fas;
    flush_vaddr = v.fvaddr;
    flush_asid = v.fasid;
    lookup_valid = v.lk;
    lookup_vaddr = v.va;
    lookup_asid = v.asid;
    lookup_is_store = v.st;
    lookup_is_fetch = v.fe;
    privilege_mode = v.priv;
    mstatus_sum = v.sum;
    mstatus_mxr = v.mxr;
    translation_enabled = v.te;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // basic ASID-tagged 4 KiB page
    push(upd(base(), 32'h12345, 32'h00ABC, 8'hCF, 2'd0, 9'd3), 1);
    push(lk(32'h12345678, 9'd3, 1, 32'h00ABC678, 0), 1);
    push(lk(32'h12345678, 9'd4, 0, 32'h0, 0), 1);
    v = lk(32'h12345678, 9'd3, 1, 32'h00ABC678, 0); v.st = 1;
    push(v, 1);
    v = lk(32'h12345678, 9'd3, 1, 32'h00ABC678, 0); v.fe = 1;
    push(v, 1);
    v = lk(32'h12345678, 9'd3, 1, 32'h00ABC678, 1); v.priv = 2'd0;
    push(v, 1);
    v = lk(32'hDEADBEEF, 9'd3, 1, 32'hDEADBEEF, 0); v.te = 0;
    push(v, 1);
    push(upd(lk(32'h55555123, 9'd3, 0, 32'h0, 0),
             32'h55555, 32'h66666, 8'hCF, 2'd0, 9'd3), 2);
    push(lk(32'h55555123, 9'd3, 1, 32'h66666123, 0), 2);
    // flush-all with fill; lookup sees pre-flush table
    push(upd(fl(lk(32'h12345678, 9'd3, 1, 32'h00ABC678, 0),
                0, 0, 32'h0, 9'd0),
             32'h12345, 32'h00ABC, 8'hEF, 2'd0, 9'd3), 1);
    push(lk(32'h12345678, 9'd7, 1, 32'h00ABC678, 0), 1);
    push(lk(32'h55555123, 9'd3, 0, 32'h0, 0), 1);
    push(fl(base(), 0, 1, 32'h0, 9'd3), 1);
    push(lk(32'h12345678, 9'd7, 1, 32'h00ABC678, 0), 1);
    push(fl(base(), 1, 0, 32'h12345000, 9'd0), 0);
    push(lk(32'h12345678, 9'd7, 0, 32'h0, 0), 0);
    // megapage and misaligned refill
    push(upd(base(), 32'h10000, 32'h20000, 8'hCF, 2'd1, 9'd3), 1);
    push(lk(32'h103FF123, 9'd3, 1, 32'h203FF123, 0), 1);
    push(upd(base(), 32'h10000, 32'h20001, 8'hCF, 2'd1, 9'd3), 1);
    push(lk(32'h103FF123, 9'd3, 1, 32'h203FF123, 1), 1);
    // A/D bits
    push(upd(base(), 32'h00050, 32'h00060, 8'h4F, 2'd0, 9'd3), 2);
    push(lk(32'h00050ABC, 9'd3, 1, 32'h00060ABC, 0), 2);
    v = lk(32'h00050ABC, 9'd3, 1, 32'h00060ABC, 1); v.st = 1;
    push(v, 2);
    push(upd(base(), 32'h00050, 32'h00060, 8'h8F, 2'd0, 9'd3), 2);
    push(lk(32'h00050ABC, 9'd3, 1, 32'h00060ABC, 1), 2);
    // U/SUM, MXR, W-without-R
    push(upd(base(), 32'h00070, 32'h00080, 8'hDF, 2'd0, 9'd3), 3);
    push(lk(32'h00070010, 9'd3, 1, 32'h00080010, 1), 3);
    v = lk(32'h00070010, 9'd3, 1, 32'h00080010, 0); v.sum = 1;
    push(v, 3);
    v = lk(32'h00070010, 9'd3, 1, 32'h00080010, 1);
    v.sum = 1; v.fe = 1;
    push(v, 3);
    v = lk(32'h00070010, 9'd3, 1, 32'h00080010, 0);
    v.priv = 2'd0; v.fe = 1;
    push(v, 3);
    push(upd(base(), 32'h00090, 32'h000A0, 8'hC9, 2'd0, 9'd3), 4);
    push(lk(32'h00090004, 9'd3, 1, 32'h000A0004, 1), 4);
    v = lk(32'h00090004, 9'd3, 1, 32'h000A0004, 0); v.mxr = 1;
    push(v, 4);
    v = lk(32'h00090004, 9'd3, 1, 32'h000A0004, 0); v.fe = 1;
    push(v, 4);
    v = lk(32'h00090004, 9'd3, 1, 32'h000A0004, 1); v.st = 1;
    push(v, 4);
    push(upd(base(), 32'h000B0, 32'h000C0, 8'hC5, 2'd0, 9'd3), 5);
    push(lk(32'h000B0008, 9'd3, 1, 32'h000C0008, 1), 5);
    // flush with both operands
    push(fl(base(), 1, 1, 32'h00070000, 9'd3), 4);
    push(lk(32'h00070010, 9'd3, 0, 32'h0, 0), 4);
    push(fl(base(), 1, 1, 32'h00090000, 9'd4), 4);
    v = lk(32'h00090004, 9'd3, 1, 32'h000A0004, 0); v.mxr = 1;
    push(v, 4);
    // multiple matches: lowest index wins
    push(fl(base(), 0, 0, 32'h0, 9'd0), 0);
    push(upd(base(), 32'h00777, 32'h00111, 8'hEF, 2'd0, 9'd2), 1);
    push(upd(base(), 32'h00777, 32'h00222, 8'hCF, 2'd0, 9'd5), 2);
    push(lk(32'h00777ABC, 9'd5, 1, 32'h00111ABC, 0), 2);
    // NRU replacement
    push(fl(base(), 0, 0, 32'h0, 9'd0), 0);
    for (int i = 0; i < 16; i++)
      push(upd(base(), 32'h100 + i, 32'h200 + i, 8'hCF, 2'd0, 9'd1),
           5'(i + 1));
    for (int i = 0; i < 14; i++)
      push(lk(((32'h100 + i) << 12) | 32'h34, 9'd1, 1,
              ((32'h200 + i) << 12) | 32'h34, 0), 16);
    push(upd(base(), 32'h300, 32'h400, 8'hCF, 2'd0, 9'd1), 16);
    push(lk(32'h00300034, 9'd1, 1, 32'h00400034, 0), 16);
    push(lk(32'h0010E034, 9'd1, 0, 32'h0, 0), 16);
    push(lk(32'h0010F034, 9'd1, 1, 32'h0020F034, 0), 16);

    reset_n = 1'b0;
    drive(base());
    #12;
    n_vec++;
    chk("rst_valid", -1, 32'(resp_valid), 32'd0);
    chk("rst_hit", -1, 32'(resp_hit), 32'd0);
    chk("rst_paddr", -1, resp_paddr, 32'd0);
    chk("rst_fault", -1, 32'(resp_page_fault), 32'd0);
    chk("rst_occ", -1, 32'(occupancy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k]);
      @(posedge clk);
      #1;
      n_vec++;
      chk("resp_valid", k, 32'(resp_valid), 32'(tbl[k].lk));
      if (tbl[k].lk) begin
        chk("resp_hit", k, 32'(resp_hit), 32'(tbl[k].ehit));
        chk("resp_paddr", k, resp_paddr, tbl[k].epa);
        chk("resp_fault", k, 32'(resp_page_fault), 32'(tbl[k].eflt));
      end
      chk("occupancy", k, 32'(occupancy), 32'(tbl[k].eocc));
    end

    // reset in the middle of a lookup
    @(negedge clk);
    drive(lk(32'h00300034, 9'd1, 1, 32'h00400034, 0));
    @(posedge clk);
    #1;
    n_vec++;
    chk("pre_rst_hit", -2, 32'(resp_hit), 32'd1);
    chk("pre_rst_paddr", -2, resp_paddr, 32'h00400034);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    chk("async_rst_valid", -2, 32'(resp_valid), 32'd0);
    chk("async_rst_hit", -2, 32'(resp_hit), 32'd0);
    chk("async_rst_occ", -2, 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
    n_vec++;
    chk("held_rst_valid", -2, 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk("post_rst_valid", -2, 32'(resp_valid), 32'd1);
    chk("post_rst_hit", -2, 32'(resp_hit), 32'd0);
    chk("post_rst_paddr", -2, resp_paddr, 32'd0);
    chk("post_rst_occ", -2, 32'(occupancy), 32'd0);

    @(negedge clk);
    drive(base());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
